// File: rtl/jogo_playseq_pkg.sv
// Shared types, constants and helpers for the jogo_playseq sequence-memory game.
package jogo_playseq_pkg;

    localparam int unsigned MOVE_W    = 4;
    localparam int unsigned MEM_SEQS  = 4;
    localparam int unsigned MEM_DEPTH = 16;
    localparam int unsigned ADDR_W    = 6;

    typedef enum logic [3:0] {
        INICIAL,
        PREPARA,
        MOSTRA_ON,
        MOSTRA_OFF,
        ESPERA,
        REGISTRA,
        SOLTA_JOGADA,
        SOLTA_RODADA,
        GANHOU,
        PERDEU
    } state_t;

    // Power-on / reset contents of the four stored sequences
    localparam logic [MOVE_W-1:0] INIT_TABLE [MEM_SEQS][MEM_DEPTH] = '{
        '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8},
        '{4'h1, 4'h2, 4'h8, 4'h4, 4'h2, 4'h8, 4'h4, 4'h1, 4'h8, 4'h4, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h8},
        '{4'h8, 4'h2, 4'h1, 4'h4, 4'h2, 4'h1, 4'h4, 4'h8, 4'h1, 4'h4, 4'h8, 4'h2, 4'h4, 4'h8, 4'h2, 4'h1},
        '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1}
    };

    // Per-move timeout in seconds selected by timeoutD
    function automatic int unsigned timeout_secs(input logic [1:0] sel);
        case (sel)
            2'd0:    return 20;
            2'd1:    return 10;
            2'd2:    return 5;
            default: return 2;
        endcase
    endfunction

    // A legal move is exactly one button
    function automatic logic is_one_hot(input logic [MOVE_W-1:0] v);
        return (v != '0) && ((v & (v - MOVE_W'(1))) == '0);
    endfunction

    // Hex digit to active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        case (v)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

endpackage

// File: rtl/jogo_playseq_mem.sv
// 4 sequences x 16 moves RAM; async read, sync write, reloaded from INIT_TABLE on reset.
module jogo_playseq_mem
    import jogo_playseq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [MOVE_W-1:0] wdata,
    output logic [MOVE_W-1:0] rdata
);

    logic [MOVE_W-1:0] mem [MEM_SEQS][MEM_DEPTH];

    // Storage: reset restores the built-in sequences, otherwise optional write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < int'(MEM_SEQS); m++) begin
                for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                    mem[m][i] <= INIT_TABLE[m][i];
                end
            end
        end else if (we) begin
            mem[addr[5:4]][addr[3:0]] <= wdata;
        end
    end

    assign rdata = mem[addr[5:4]][addr[3:0]];

endmodule

// File: rtl/jogo_playseq.sv
// Sequence-memory game core: replay, player entry, win/loss tracking.
// Optional per-move timeout enabled by `define JOGO_PLAYSEQ_TIMEOUT_EN.
module jogo_playseq
    import jogo_playseq_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 1000,
    parameter int unsigned INIT_LEN = 9,
    parameter int unsigned SEQ_LEN  = 16
) (
    input  logic       clockFPGA,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    input  logic [1:0] nivel,
    input  logic [1:0] memoria,
    input  logic [1:0] timeoutD,
    input  logic       quer_escrever,
    output logic       ganhou,
    output logic       perdeu,
    output logic [3:0] leds,
    output logic       db_clock,
    output logic [6:0] vitorias,
    output logic [6:0] derrotas
);

    localparam int unsigned HALF = CLK_HZ / 2;
    localparam int unsigned CW   = $clog2(20 * CLK_HZ + 1);
    localparam int unsigned PW   = 5;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     pos, len, pos_nxt, alvo;
    logic [1:0]        niv_q, mem_q;
    logic              esc_q, jogar_q;
    logic [3:0]        bot_q, jogada, wins, losses;
    logic [MOVE_W-1:0] rdata;
    logic              press, jogar_rise, half_done, move_ok;
    logic              cnt_clr_c, cnt_inc_c, start_c, pos_clr_c, pos_inc_c;
    logic              len_ld_c, grab_c, wr_c, win_c, lose_c;
    logic [3:0]        leds_c;
`ifdef JOGO_PLAYSEQ_TIMEOUT_EN
    logic [1:0]        tmo_q;
    logic [CW-1:0]     tmo_lim;
    assign tmo_lim = CW'(timeout_secs(tmo_q) * CLK_HZ);
`else
    logic              unused_tmo;
    assign unused_tmo = ^timeoutD;
`endif

    assign db_clock   = clockFPGA;
    assign jogar_rise = jogar & ~jogar_q;
    assign press      = (bot_q == 4'h0) && (botoes != 4'h0);
    assign half_done  = (cnt == CW'(HALF - 1));
    assign pos_nxt    = pos + PW'(1);
    assign alvo       = len + PW'(niv_q) + PW'(1);
    assign move_ok    = is_one_hot(jogada) && (esc_q || (jogada == rdata));

    jogo_playseq_mem u_mem (
        .clk   (clockFPGA),
        .rst_n (reset),
        .we    (wr_c),
        .addr  ({mem_q, pos[3:0]}),
        .wdata (jogada),
        .rdata (rdata)
    );

    // State register
    always_ff @(posedge clockFPGA or negedge reset) begin
        if (!reset) state <= INICIAL;
        else        state <= state_n;
    end

    // Next state and datapath strobes
    always_comb begin
        state_n   = state;
        cnt_clr_c = 1'b0;
        cnt_inc_c = 1'b0;
        start_c   = 1'b0;
        pos_clr_c = 1'b0;
        pos_inc_c = 1'b0;
        len_ld_c  = 1'b0;
        grab_c    = 1'b0;
        wr_c      = 1'b0;
        win_c     = 1'b0;
        lose_c    = 1'b0;
        leds_c    = 4'h0;
        case (state)
            INICIAL, GANHOU, PERDEU: begin
                if (jogar_rise) begin
                    start_c = 1'b1;
                    state_n = PREPARA;
                end
            end
            PREPARA: begin
                pos_clr_c = 1'b1;
                cnt_clr_c = 1'b1;
                state_n   = MOSTRA_ON;
            end
            MOSTRA_ON: begin
                leds_c = rdata;
                if (half_done) begin
                    cnt_clr_c = 1'b1;
                    state_n   = MOSTRA_OFF;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            MOSTRA_OFF: begin
                if (half_done) begin
                    cnt_clr_c = 1'b1;
                    pos_inc_c = 1'b1;
                    state_n   = (pos_nxt == len) ? ESPERA : MOSTRA_ON;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            ESPERA: begin
                leds_c = botoes;
                if (press) begin
                    grab_c    = 1'b1;
                    cnt_clr_c = 1'b1;
                    state_n   = REGISTRA;
                end
`ifdef JOGO_PLAYSEQ_TIMEOUT_EN
                else if (cnt >= tmo_lim - CW'(1)) begin
                    lose_c  = 1'b1;
                    state_n = PERDEU;
                end else begin
                    cnt_inc_c = 1'b1;
                end
`endif
            end
            REGISTRA: begin
                leds_c = botoes;
                if (move_ok) begin
                    wr_c      = esc_q;
                    pos_inc_c = 1'b1;
                    if (pos_nxt == PW'(SEQ_LEN)) begin
                        win_c   = 1'b1;
                        state_n = GANHOU;
                    end else if (pos_nxt == alvo) begin
                        state_n = SOLTA_RODADA;
                    end else begin
                        state_n = SOLTA_JOGADA;
                    end
                end else begin
                    lose_c  = 1'b1;
                    state_n = PERDEU;
                end
            end
            SOLTA_JOGADA: begin
                leds_c = botoes;
                if (botoes == 4'h0) begin
                    cnt_clr_c = 1'b1;
                    state_n   = ESPERA;
                end
            end
            SOLTA_RODADA: begin
                leds_c = botoes;
                if (botoes == 4'h0) begin
                    len_ld_c = 1'b1;
                    state_n  = PREPARA;
                end
            end
            default: state_n = INICIAL;
        endcase
    end

    // Timers, pointers, latched settings, flags and score counters
    always_ff @(posedge clockFPGA or negedge reset) begin
        if (!reset) begin
            jogar_q  <= 1'b0;
            bot_q    <= 4'h0;
            leds     <= 4'h0;
            cnt      <= '0;
            pos      <= '0;
            len      <= PW'(INIT_LEN);
            niv_q    <= 2'd0;
            mem_q    <= 2'd0;
            esc_q    <= 1'b0;
            jogada   <= 4'h0;
            ganhou   <= 1'b0;
            perdeu   <= 1'b0;
            wins     <= 4'h0;
            losses   <= 4'h0;
            vitorias <= 7'b1000000;
            derrotas <= 7'b1000000;
`ifdef JOGO_PLAYSEQ_TIMEOUT_EN
            tmo_q    <= 2'd0;
`endif
        end else begin
            jogar_q <= jogar;
            bot_q   <= botoes;
            leds    <= leds_c;
            if (cnt_clr_c)      cnt <= '0;
            else if (cnt_inc_c) cnt <= cnt + CW'(1);
            if (pos_clr_c)      pos <= '0;
            else if (pos_inc_c) pos <= pos_nxt;
            if (len_ld_c)       len <= pos;
            if (grab_c)         jogada <= botoes;
            if (start_c) begin
                niv_q  <= nivel;
                mem_q  <= memoria;
                esc_q  <= quer_escrever;
                len    <= PW'(INIT_LEN);
                ganhou <= 1'b0;
                perdeu <= 1'b0;
`ifdef JOGO_PLAYSEQ_TIMEOUT_EN
                tmo_q  <= timeoutD;
`endif
            end
            if (win_c) begin
                ganhou   <= 1'b1;
                wins     <= wins + 4'd1;
                vitorias <= hex7seg(wins + 4'd1);
            end
            if (lose_c) begin
                perdeu   <= 1'b1;
                losses   <= losses + 4'd1;
                derrotas <= hex7seg(losses + 4'd1);
            end
        end
    end

endmodule

// File: tb/tb_jogo_playseq.sv
// Directed self-checking bench for jogo_playseq (CLK_HZ scaled down to 100 to keep runs short).
module tb_jogo_playseq;

    localparam int CLK_HZ = 100;
    localparam int HALF   = CLK_HZ / 2;

    logic       clk = 1'b0;
    logic       reset, jogar, quer_escrever;
    logic [3:0] botoes;
    logic [1:0] nivel, memoria, timeoutD;
    logic       ganhou, perdeu, db_clock;
    logic [3:0] leds;
    logic [6:0] vitorias, derrotas;

    jogo_playseq #(.CLK_HZ(CLK_HZ), .INIT_LEN(9), .SEQ_LEN(16)) dut (
        .clockFPGA     (clk),
        .reset         (reset),
        .jogar         (jogar),
        .botoes        (botoes),
        .nivel         (nivel),
        .memoria       (memoria),
        .timeoutD      (timeoutD),
        .quer_escrever (quer_escrever),
        .ganhou        (ganhou),
        .perdeu        (perdeu),
        .leds          (leds),
        .db_clock      (db_clock),
        .vitorias      (vitorias),
        .derrotas      (derrotas)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] btn;
        int         show;
        logic       exp_g;
        logic       exp_p;
    } step_t;

    step_t      win_steps [7];
    logic [3:0] seq [16];
    logic [6:0] seg [16];
    int n_chk = 0, n_pass = 0, t_start = 0, exp_wins = 0, exp_losses = 0;

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_game();
        @(negedge clk);
        jogar   = 1'b1;
        t_start = cyc + 1;
        @(negedge clk);
        jogar   = 1'b0;
    endtask

    // Sample the middle of each on/off half, then one slot past the end of the round
    task automatic check_show(input int n);
        for (int k = 0; k < n; k++) begin
            wait_to(t_start + 1 + CLK_HZ * k + HALF / 2);
            check("show_on", {4'h0, leds}, {4'h0, seq[k]});
            wait_to(t_start + 1 + CLK_HZ * k + HALF + HALF / 2);
            check("show_off", {4'h0, leds}, 8'h00);
        end
        wait_to(t_start + 1 + CLK_HZ * n + HALF / 2);
        check("show_len", {4'h0, leds}, 8'h00);
    endtask

    task automatic press(input logic [3:0] v, input logic exp_g, input logic exp_p);
        @(negedge clk);
        botoes = v;
        repeat (4) @(negedge clk);
        check("flag_ganhou", {7'd0, ganhou}, {7'd0, exp_g});
        check("flag_perdeu", {7'd0, perdeu}, {7'd0, exp_p});
        botoes  = 4'h0;
        t_start = cyc + 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_scores();
        check("vitorias", {1'b0, vitorias}, {1'b0, seg[exp_wins]});
        check("derrotas", {1'b0, derrotas}, {1'b0, seg[exp_losses]});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        seq = '{4'h1, 4'h2, 4'h8, 4'h4, 4'h2, 4'h8, 4'h4, 4'h1,
                4'h8, 4'h4, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h8};
        seg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        win_steps = '{
            '{4'h4,  9, 1'b0, 1'b0},
            '{4'h1,  0, 1'b0, 1'b0},
            '{4'h2, 11, 1'b0, 1'b0},
            '{4'h4,  0, 1'b0, 1'b0},
            '{4'h1, 13, 1'b0, 1'b0},
            '{4'h2,  0, 1'b0, 1'b0},
            '{4'h8, 15, 1'b1, 1'b0}
        };

        reset = 1'b0; jogar = 1'b0; botoes = 4'h0; nivel = 2'd0;
        memoria = 2'd0; timeoutD = 2'd0; quer_escrever = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ganhou", {7'd0, ganhou}, 8'd0);
        check("rst_perdeu", {7'd0, perdeu}, 8'd0);
        check("rst_leds", {4'h0, leds}, 8'h00);
        check_scores();
        check("db_clock", {7'd0, db_clock}, {7'd0, clk});
        reset = 1'b1;
        @(negedge clk);

        // Full winning game on memoria 1, K=2
        nivel = 2'd1; memoria = 2'd1; timeoutD = 2'd0;
        start_game();
        for (int s = 0; s < 7; s++) begin
            if (win_steps[s].show != 0) check_show(win_steps[s].show);
            press(win_steps[s].btn, win_steps[s].exp_g, win_steps[s].exp_p);
        end
        exp_wins++;
        check_scores();

`ifdef JOGO_PLAYSEQ_TIMEOUT_EN
        // 10 s timeout then 5 s timeout
        timeoutD = 2'd1;
        start_game();
        @(negedge clk);
        check("restart_ganhou", {7'd0, ganhou}, 8'd0);
        wait_to(t_start + 1 + 9 * CLK_HZ + (CLK_HZ * 95) / 10);
        check("tmo10_early", {7'd0, perdeu}, 8'd0);
        wait_to(t_start + 1 + 9 * CLK_HZ + (CLK_HZ * 105) / 10);
        check("tmo10_late", {7'd0, perdeu}, 8'd1);
        exp_losses++;
        check_scores();
        timeoutD = 2'd2;
        start_game();
        @(negedge clk);
        check("restart_perdeu", {7'd0, perdeu}, 8'd0);
        wait_to(t_start + 1 + 9 * CLK_HZ + (CLK_HZ * 45) / 10);
        check("tmo5_early", {7'd0, perdeu}, 8'd0);
        wait_to(t_start + 1 + 9 * CLK_HZ + (CLK_HZ * 55) / 10);
        check("tmo5_late", {7'd0, perdeu}, 8'd1);
        exp_losses++;
        check_scores();
`else
        // No timeout: a 21 s idle wait must not lose; a non-one-hot press does
        timeoutD = 2'd3;
        start_game();
        @(negedge clk);
        check("restart_ganhou", {7'd0, ganhou}, 8'd0);
        wait_to(t_start + 1 + 9 * CLK_HZ + 21 * CLK_HZ);
        check("no_tmo", {7'd0, perdeu}, 8'd0);
        press(4'b0101, 1'b0, 1'b1);
        exp_losses++;
        check_scores();
`endif

        // Wrong move: loss appears on the clock after the press is registered
        timeoutD = 2'd0;
        start_game();
        wait_to(t_start + 1 + 9 * CLK_HZ + 10);
        botoes = 4'h8;
        @(negedge clk);
        check("echo_leds", {4'h0, leds}, 8'h08);
        check("wrong_pre", {7'd0, perdeu}, 8'd0);
        @(negedge clk);
        check("wrong_post", {7'd0, perdeu}, 8'd1);
        botoes = 4'h0;
        exp_losses++;
        check_scores();
        start_game();
        check_show(9);
        press(4'h4, 1'b0, 1'b0);
        press(4'h2, 1'b0, 1'b1);
        exp_losses++;
        check_scores();

        // Write mode records moves 9 and 10
        quer_escrever = 1'b1;
        start_game();
        check_show(9);
        press(4'h2, 1'b0, 1'b0);
        press(4'h2, 1'b0, 1'b0);
        seq[9]  = 4'h2;
        seq[10] = 4'h2;
        check_show(11);
        press(4'b0011, 1'b0, 1'b1);
        exp_losses++;

        // Check mode sees the recorded moves
        quer_escrever = 1'b0;
        start_game();
        check_show(9);
        press(4'h2, 1'b0, 1'b0);
        press(4'h2, 1'b0, 1'b0);
        check_show(11);
        press(4'h8, 1'b0, 1'b1);
        exp_losses++;
        check_scores();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
